// File: rtl/riscv_dm_abstract_cmd.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dm_abstract_cmd
// Brief    : RISC-V debug module abstract-command block. Holds the DATA,
//            PROGBUF, ABSTRACTCS, COMMAND and ABSTRACTAUTO registers behind
//            a DMI request/response port and offers validated commands to
//            an executor.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dm_abstract_cmd #(
    parameter int DATACOUNT   = 2,
    parameter int PROGBUFSIZE = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      dmi_req_valid_i,
    output logic                      dmi_req_ready_o,
    input  logic [40:0]               dmi_req_i,
    output logic                      dmi_resp_valid_o,
    input  logic                      dmi_resp_ready_i,
    output logic [33:0]               dmi_resp_o,
    input  logic                      halted_i,
    output logic                      cmd_valid_o,
    output logic [31:0]               cmd_o,
    input  logic                      cmd_ready_i,
    input  logic                      cmd_done_i,
    input  logic                      cmd_exc_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_idx_i,
    input  logic [31:0]               data_i,
    output logic [32*DATACOUNT-1:0]   data_o,
    input  logic [4:0]                progbuf_idx_i,
    output logic [31:0]               progbuf_o
);

    localparam logic [1:0]  c_op_read      = 2'd1;
    localparam logic [1:0]  c_op_write     = 2'd2;
    localparam logic [6:0]  c_addr_data0   = 7'h04;
    localparam logic [6:0]  c_addr_acs     = 7'h16;
    localparam logic [6:0]  c_addr_command = 7'h17;
    localparam logic [6:0]  c_addr_auto    = 7'h18;
    localparam logic [6:0]  c_addr_pb0     = 7'h20;
    localparam logic [31:0] c_ebreak       = 32'h0010_0073;
    localparam int          c_pb_n         = (PROGBUFSIZE > 0) ? PROGBUFSIZE : 1;
    localparam logic [15:0] c_ad_mask      = 16'((1 << DATACOUNT) - 1);
    localparam logic [15:0] c_pb_mask      = 16'((1 << PROGBUFSIZE) - 1);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_issue = 2'd1;
    localparam logic [1:0]  c_st_wait  = 2'd2;

    logic [1:0]  r_state, w_state_next;
    logic [2:0]  r_cmderr, w_cmderr_set;
    logic [31:0] r_command;
    logic [31:0] r_data    [DATACOUNT];
    logic [31:0] r_progbuf [c_pb_n];
    logic [15:0] r_auto_data, r_auto_pb;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic [31:0] w_rdata, w_trig_cmd;
    logic        w_busy;

    // Request decode
    logic [6:0]  w_addr, w_data_off, w_pb_off;
    logic [31:0] w_wdata;
    logic        w_fire, w_rd, w_wr, w_is_data, w_is_pb, w_auto_hit;
    logic        w_ok, w_cmd_trig, w_trigger, w_unsupported, w_trigger_ok, w_busy_err;

    assign w_addr      = dmi_req_i[40:34];
    assign w_wdata     = dmi_req_i[33:2];
    assign w_fire      = dmi_req_valid_i && dmi_req_ready_o;
    assign w_rd        = w_fire && (dmi_req_i[1:0] == c_op_read);
    assign w_wr        = w_fire && (dmi_req_i[1:0] == c_op_write);
    // Offsets wrap to large values below the window base, so one compare suffices
    assign w_data_off  = w_addr - c_addr_data0;
    assign w_pb_off    = w_addr - c_addr_pb0;
    assign w_is_data   = (w_data_off < 7'(DATACOUNT));
    assign w_is_pb     = (w_pb_off < 7'(PROGBUFSIZE));
    assign w_auto_hit  = (w_rd || w_wr) &&
                         ((w_is_data && r_auto_data[w_data_off[3:0]]) ||
                          (w_is_pb && r_auto_pb[w_pb_off[3:0]]));
    assign w_ok        = !w_busy && (r_cmderr == 3'd0);
    assign w_cmd_trig  = w_wr && (w_addr == c_addr_command) && w_ok;
    assign w_trigger   = w_cmd_trig || (w_auto_hit && w_ok);
    // A COMMAND write triggers with the freshly written value, autoexec with the latched one
    assign w_trig_cmd  = w_cmd_trig ? w_wdata : r_command;
    assign w_unsupported = (w_trig_cmd[31:24] != 8'd0) ||
                           ((w_trig_cmd[22:20] != 3'd2) && (w_trig_cmd[22:20] != 3'd3));
    assign w_trigger_ok  = w_trigger && !w_unsupported && halted_i;
    assign w_busy_err    = w_wr && w_busy &&
                           (w_is_data || w_is_pb || (w_addr == c_addr_command) || (w_addr == c_addr_auto));

    assign dmi_req_ready_o  = !r_resp_valid || dmi_resp_ready_i;
    assign dmi_resp_valid_o = r_resp_valid;
    assign dmi_resp_o       = {r_resp_data, 2'b00};
    assign cmd_o            = r_command;

    for (genvar gi = 0; gi < DATACOUNT; gi++) begin : g_data_out
        assign data_o[32*gi +: 32] = r_data[gi];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    // Next-state: done/ready only matter in the state that waits for them
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_trigger_ok) w_state_next = c_st_issue;
            c_st_issue: if (cmd_ready_i)  w_state_next = c_st_wait;
            c_st_wait:  if (cmd_done_i)   w_state_next = c_st_idle;
            default:                      w_state_next = c_st_idle;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_valid_o = (r_state == c_st_issue);
        w_busy      = (r_state != c_st_idle);
    end

    // Error source selection; only applied while cmderr is clear
    always_comb begin
        w_cmderr_set = 3'd0;
        if ((r_state == c_st_wait) && cmd_done_i && cmd_exc_i) w_cmderr_set = 3'd3;
        else if (w_busy_err)                                   w_cmderr_set = 3'd1;
        else if (w_trigger && w_unsupported)                   w_cmderr_set = 3'd2;
        else if (w_trigger && !halted_i)                       w_cmderr_set = 3'd4;
    end

    // DMI read data, sampled from the pre-write register contents
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            if (w_is_data) begin
                for (int i = 0; i < DATACOUNT; i++)
                    if (w_data_off == 7'(i)) w_rdata = r_data[i];
            end else if (w_is_pb) begin
                for (int i = 0; i < PROGBUFSIZE; i++)
                    if (w_pb_off == 7'(i)) w_rdata = r_progbuf[i];
            end else if (w_addr == c_addr_acs) begin
                w_rdata = {3'd0, 5'(PROGBUFSIZE), 11'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'(DATACOUNT)};
            end else if (w_addr == c_addr_auto) begin
                w_rdata = {r_auto_pb, r_auto_data};
            end
        end
    end

    // Program buffer read port for the executor, EBREAK past the end
    always_comb begin
        progbuf_o = c_ebreak;
        for (int i = 0; i < PROGBUFSIZE; i++)
            if (progbuf_idx_i == 5'(i)) progbuf_o = r_progbuf[i];
    end

    // Response channel: load on fire, drop once the host takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
        end else if (w_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_rdata;
        end else if (dmi_resp_ready_i) begin
            r_resp_valid <= 1'b0;
        end
    end

    // cmderr: sticky once set, cleared by W1C writes to ABSTRACTCS
    always_ff @(posedge clk_i) begin
        if (rst_i)                                  r_cmderr <= 3'd0;
        else if (r_cmderr == 3'd0)                  r_cmderr <= w_cmderr_set;
        else if (w_wr && (w_addr == c_addr_acs))    r_cmderr <= r_cmderr & ~w_wdata[10:8];
    end

    // Register file updates; DMI writes are blocked while busy and win over hart writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_command   <= 32'd0;
            r_auto_data <= 16'd0;
            r_auto_pb   <= 16'd0;
            for (int i = 0; i < DATACOUNT; i++) r_data[i]    <= 32'd0;
            for (int i = 0; i < c_pb_n; i++)    r_progbuf[i] <= 32'd0;
        end else begin
            if (w_cmd_trig) r_command <= w_wdata;
            if (w_wr && !w_busy && (w_addr == c_addr_auto)) begin
                r_auto_data <= w_wdata[15:0] & c_ad_mask;
                r_auto_pb   <= w_wdata[31:16] & c_pb_mask;
            end
            for (int i = 0; i < DATACOUNT; i++) begin
                if (w_wr && !w_busy && w_is_data && (w_data_off == 7'(i)))
                    r_data[i] <= w_wdata;
                else if (data_we_i && (data_idx_i == 4'(i)))
                    r_data[i] <= data_i;
            end
            for (int i = 0; i < PROGBUFSIZE; i++)
                if (w_wr && !w_busy && w_is_pb && (w_pb_off == 7'(i)))
                    r_progbuf[i] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dm_abstract_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dm_abstract_cmd
// Brief    : Self-checking bench for riscv_dm_abstract_cmd: directed scenarios
//            with literal expectations, then randomized traffic against a
//            behavioural model of the debug-module register semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dm_abstract_cmd;

    localparam int          DC     = 2;
    localparam int          PB     = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        dmi_req_valid_i, dmi_req_ready_o;
    logic [40:0] dmi_req_i;
    logic        dmi_resp_valid_o, dmi_resp_ready_i;
    logic [33:0] dmi_resp_o;
    logic        halted_i, cmd_valid_o, cmd_ready_i, cmd_done_i, cmd_exc_i;
    logic [31:0] cmd_o;
    logic        data_we_i;
    logic [3:0]  data_idx_i;
    logic [31:0] data_i;
    logic [32*DC-1:0] data_o;
    logic [4:0]  progbuf_idx_i;
    logic [31:0] progbuf_o;

    always #5 clk = ~clk;

    riscv_dm_abstract_cmd #(.DATACOUNT(DC), .PROGBUFSIZE(PB)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o), .dmi_req_i(dmi_req_i),
        .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i), .dmi_resp_o(dmi_resp_o),
        .halted_i(halted_i), .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_ready_i(cmd_ready_i),
        .cmd_done_i(cmd_done_i), .cmd_exc_i(cmd_exc_i),
        .data_we_i(data_we_i), .data_idx_i(data_idx_i), .data_i(data_i), .data_o(data_o),
        .progbuf_idx_i(progbuf_idx_i), .progbuf_o(progbuf_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Behavioural model: register contents plus the command's life cycle
    logic [31:0] m_data [DC];
    logic [31:0] m_pb   [PB];
    logic [DC-1:0] m_auto_d;
    logic [PB-1:0] m_auto_p;
    logic [31:0] m_cmd;
    logic [2:0]  m_cmderr;
    bit          m_offered, m_running;   // command offered / accepted and executing
    bit          m_rv;
    logic [31:0] m_rd;
    bit          m_live = 0;

    task automatic model_step();
        logic [6:0] a; logic [31:0] d, rdata, tc;
        bit busy, fire, rd, wr, isd, isp, auto_hit, ok, cwr, trig, unsup, berr, exc;
        if (rst_i) begin
            for (int i = 0; i < DC; i++) m_data[i] = 0;
            for (int i = 0; i < PB; i++) m_pb[i] = 0;
            m_auto_d = 0; m_auto_p = 0; m_cmd = 0; m_cmderr = 0;
            m_offered = 0; m_running = 0; m_rv = 0; m_rd = 0; m_live = 1;
            return;
        end
        busy  = m_offered || m_running;
        fire  = dmi_req_valid_i && (!m_rv || dmi_resp_ready_i);
        a     = dmi_req_i[40:34];
        d     = dmi_req_i[33:2];
        rd    = fire && dmi_req_i[1:0] == 2'd1;
        wr    = fire && dmi_req_i[1:0] == 2'd2;
        isd   = a >= 4 && a < 4 + DC;
        isp   = a >= 32 && a < 32 + PB;
        rdata = 0;
        if (rd) begin
            if (isd)           rdata = m_data[a-4];
            else if (isp)      rdata = m_pb[a-32];
            else if (a == 22)  rdata = (PB << 24) + (int'(busy) << 12) + (int'(m_cmderr) << 8) + DC;
            else if (a == 24)  rdata = (32'(m_auto_p) << 16) + 32'(m_auto_d);
        end
        if (fire) begin m_rv = 1; m_rd = rdata; end
        else if (dmi_resp_ready_i) m_rv = 0;
        auto_hit = (rd || wr) && ((isd && m_auto_d[a-4]) || (isp && m_auto_p[a-32]));
        ok    = !busy && m_cmderr == 0;
        cwr   = wr && a == 23;
        trig  = ok && (cwr || auto_hit);
        tc    = cwr ? d : m_cmd;
        unsup = tc[31:24] != 0 || !(tc[22:20] == 2 || tc[22:20] == 3);
        berr  = wr && busy && (isd || isp || a == 23 || a == 24);
        exc   = m_running && cmd_done_i && cmd_exc_i;
        if (m_cmderr == 0) begin
            if (exc)                      m_cmderr = 3;
            else if (berr)                m_cmderr = 1;
            else if (trig && unsup)       m_cmderr = 2;
            else if (trig && !halted_i)   m_cmderr = 4;
        end else if (wr && a == 22) m_cmderr = m_cmderr & ~d[10:8];
        if (cwr && ok) m_cmd = d;
        if (data_we_i && data_idx_i < DC) m_data[data_idx_i] = data_i;
        if (wr && !busy) begin
            if (isd) m_data[a-4] = d;
            if (isp) m_pb[a-32] = d;
            if (a == 24) begin m_auto_d = d[DC-1:0]; m_auto_p = d[16+PB-1:16]; end
        end
        if (m_offered) begin
            if (cmd_ready_i) begin m_offered = 0; m_running = 1; end
        end else if (m_running) begin
            if (cmd_done_i) m_running = 0;
        end else if (trig && !unsup && halted_i) m_offered = 1;
    endtask

    task automatic compare_all();
        if (!m_live) return;
        chk("resp_valid", dmi_resp_valid_o, m_rv);
        if (m_rv) chk("resp", dmi_resp_o, {m_rd, 2'b00});
        chk("req_ready", dmi_req_ready_o, !m_rv || dmi_resp_ready_i);
        chk("cmd_valid", cmd_valid_o, m_offered);
        chk("cmd_o", cmd_o, m_cmd);
        chk("data_o", data_o, {m_data[1], m_data[0]});
        chk("progbuf_o", progbuf_o, (progbuf_idx_i < PB) ? m_pb[progbuf_idx_i] : EBREAK);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d, output logic [31:0] r);
        dmi_req_valid_i = 1; dmi_req_i = {a, d, op};
        tick();
        dmi_req_valid_i = 0;
        r = dmi_resp_o[33:2];
    endtask

    logic [31:0] r, held;
    logic [6:0]  ra;

    initial begin
        rst_i = 1; dmi_req_valid_i = 0; dmi_req_i = 0; dmi_resp_ready_i = 1;
        halted_i = 1; cmd_ready_i = 0; cmd_done_i = 0; cmd_exc_i = 0;
        data_we_i = 0; data_idx_i = 0; data_i = 0; progbuf_idx_i = 0;
        tick(); tick();
        rst_i = 0;
        chk("rst_resp_valid", dmi_resp_valid_o, 0);
        chk("rst_cmd_valid", cmd_valid_o, 0);
        chk("rst_data", data_o, 0);

        // DATA0 write/readback, response one cycle after fire
        dmi(7'h04, 2'd2, 32'h1234, r);
        dmi(7'h04, 2'd1, 0, r);
        chk("data0_rd", r, 32'h1234);
        chk("data0_op", dmi_resp_o[1:0], 0);
        chk("data0_rv", dmi_resp_valid_o, 1);

        // Supported command runs through issue/wait
        dmi(7'h17, 2'd2, 32'h0022_0300, r);
        chk("cmd_offer", cmd_valid_o, 1);
        chk("cmd_value", cmd_o, 32'h0022_0300);
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_busy", r, 32'h0800_1002);
        cmd_ready_i = 1; tick(); cmd_ready_i = 0;
        chk("cmd_taken", cmd_valid_o, 0);
        cmd_done_i = 1; tick(); cmd_done_i = 0;
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_idle", r, 32'h0800_0002);

        // COMMAND while busy -> cmderr=1, W1C clears it
        dmi(7'h17, 2'd2, 32'h0022_0300, r);
        cmd_ready_i = 1; tick(); cmd_ready_i = 0;
        dmi(7'h17, 2'd2, 32'h0032_0000, r);
        chk("busy_cmd_ignored", cmd_o, 32'h0022_0300);
        cmd_done_i = 1; tick(); cmd_done_i = 0;
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_err1", r, 32'h0800_0102);
        dmi(7'h16, 2'd2, 32'h700, r);
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_clr", r, 32'h0800_0002);

        // Unsupported command and not-halted
        dmi(7'h17, 2'd2, 32'h0100_0000, r);
        chk("unsup_no_offer", cmd_valid_o, 0);
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_err2", r, 32'h0800_0202);
        dmi(7'h16, 2'd2, 32'h700, r);
        halted_i = 0;
        dmi(7'h17, 2'd2, 32'h0022_0300, r);
        chk("nohalt_no_offer", cmd_valid_o, 0);
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_err4", r, 32'h0800_0402);
        dmi(7'h16, 2'd2, 32'h700, r);
        halted_i = 1;

        // Autoexec on DATA0 read, then exception at done
        dmi(7'h18, 2'd2, 32'hFFFF_0001, r);
        dmi(7'h18, 2'd1, 0, r);
        chk("auto_rd", r, 32'h00FF_0001);
        dmi(7'h18, 2'd2, 32'h0000_0001, r);
        dmi(7'h04, 2'd1, 0, r);
        chk("auto_offer", cmd_valid_o, 1);
        chk("auto_data", r, 32'h1234);
        cmd_ready_i = 1; tick(); cmd_ready_i = 0;
        cmd_done_i = 1; cmd_exc_i = 1; tick(); cmd_done_i = 0; cmd_exc_i = 0;
        dmi(7'h16, 2'd1, 0, r);
        chk("acs_err3", r, 32'h0800_0302);
        dmi(7'h16, 2'd2, 32'h700, r);
        dmi(7'h18, 2'd2, 0, r);

        // Program buffer port and response backpressure
        dmi(7'h20, 2'd2, 32'hDEAD_BEEF, r);
        progbuf_idx_i = 5'd8; #1;
        chk("pb_ebreak", progbuf_o, EBREAK);
        progbuf_idx_i = 5'd0; #1;
        chk("pb0", progbuf_o, 32'hDEAD_BEEF);
        tick();
        dmi_resp_ready_i = 0;
        dmi(7'h20, 2'd1, 0, held);
        chk("bp_first", held, 32'hDEAD_BEEF);
        dmi_req_valid_i = 1; dmi_req_i = {7'h04, 32'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_req_ready", dmi_req_ready_o, 0);
            chk("bp_resp_hold", dmi_resp_o[33:2], held);
        end
        dmi_resp_ready_i = 1; tick();
        dmi_req_valid_i = 0;
        chk("bp_next", dmi_resp_o[33:2], 32'h1234);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            dmi_resp_ready_i = ($urandom_range(0, 3) != 0);
            dmi_req_valid_i  = $urandom_range(0, 1);
            case ($urandom_range(0, 10))
                0, 1: ra = 7'h04;
                2:    ra = 7'h05;
                3:    ra = 7'h06;
                4, 5: ra = 7'h16;
                6, 7: ra = 7'h17;
                8:    ra = 7'h18;
                9:    ra = 7'(32 + $urandom_range(0, 8));
                default: ra = 7'(42 + $urandom_range(0, 9));
            endcase
            case (ra)
                7'h17: case ($urandom_range(0, 4))
                           0: r = 32'h0022_0300;
                           1: r = 32'h0032_1000;
                           2: r = 32'h0100_0000;
                           3: r = 32'h0012_0000;
                           default: r = $urandom;
                       endcase
                7'h16: r = $urandom_range(0, 1) ? 32'h700 : $urandom;
                default: r = $urandom;
            endcase
            dmi_req_i     = {ra, r, 2'($urandom_range(0, 3))};
            halted_i      = ($urandom_range(0, 7) != 0);
            cmd_ready_i   = $urandom_range(0, 1);
            cmd_done_i    = ($urandom_range(0, 3) == 0);
            cmd_exc_i     = ($urandom_range(0, 3) == 0);
            data_we_i     = ($urandom_range(0, 3) == 0);
            data_idx_i    = 4'($urandom_range(0, 3));
            data_i        = $urandom;
            progbuf_idx_i = 5'($urandom_range(0, 9));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
